// File: rtl/imem_boot_ctrl_if.sv
// ---------------------------------------------------------------------------
// imem_boot_ctrl_if
// Bundles the three buses of the instruction-memory boot controller:
//   load stream : ld_valid/ld_ready/ld_data/ld_last    (program download)
//   fetch port  : if_req/if_addr -> if_gnt/if_instr/if_fault
//   memory port : mem_we/mem_waddr/mem_wdata, mem_raddr -> mem_rdata
// Modports:
//   slave  : the controller (accepts loads and fetches, drives the memory)
//   master : the environment (loader, core and memory around the controller)
// ---------------------------------------------------------------------------
interface imem_boot_ctrl_if #(
    parameter int AW = 5
);
    logic          ld_valid;
    logic          ld_ready;
    logic [31:0]   ld_data;
    logic          ld_last;

    logic          if_req;
    logic [31:0]   if_addr;
    logic          if_gnt;
    logic [31:0]   if_instr;
    logic          if_fault;

    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [31:0]   mem_wdata;
    logic [AW-1:0] mem_raddr;
    logic [31:0]   mem_rdata;

    modport slave (
        input  ld_valid, ld_data, ld_last, if_req, if_addr, mem_rdata,
        output ld_ready, if_gnt, if_instr, if_fault,
               mem_we, mem_waddr, mem_wdata, mem_raddr
    );

    modport master (
        output ld_valid, ld_data, ld_last, if_req, if_addr, mem_rdata,
        input  ld_ready, if_gnt, if_instr, if_fault,
               mem_we, mem_waddr, mem_wdata, mem_raddr
    );
endinterface

// File: rtl/imem_boot_ctrl.sv
// ---------------------------------------------------------------------------
// imem_boot_ctrl
// Boot and fetch sequencer in front of a DEPTH-word instruction memory.
// After reset the program is streamed in over the load interface and written
// word by word while the core is held in reset. Once the load finishes the
// core reset is held for RST_HOLD more cycles, then released, and fetches are
// served combinationally with alignment/range checking. Memory reads and
// writes are never issued in the same cycle (writes only in LOAD, reads only
// in RUN).
// Ports:
//   clk        : system clock, rising edge
//   rst        : asynchronous active-low reset
//   bus        : load stream, fetch port and memory port (slave modport)
//   reload_req : single-cycle request (honoured in RUN) to reload the program
//   cpu_rst_n  : core reset, active-low
//   load_done  : program loaded and core released
//   load_err   : sticky, program overflowed DEPTH words
//   load_count : words written in the current load, saturates at DEPTH
// ---------------------------------------------------------------------------
module imem_boot_ctrl #(
    parameter int          DEPTH     = 32,
    parameter int          AW        = 5,
    parameter int          RST_HOLD  = 4,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                  clk,
    input  logic                  rst,
    imem_boot_ctrl_if.slave       bus,
    input  logic                  reload_req,
    output logic                  cpu_rst_n,
    output logic                  load_done,
    output logic                  load_err,
    output logic [AW:0]           load_count
);

    localparam int HW = $clog2(RST_HOLD + 1);

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_HOLD,
        ST_RUN
    } state_t;

    state_t        r_state;
    state_t        w_next_state;
    logic [AW-1:0] r_wptr;
    logic [HW-1:0] r_hold_cnt;
    logic [AW:0]   r_load_count;
    logic          r_load_err;

    logic          w_hs;
    logic          w_hold_done;
    logic          w_addr_bad;

    assign w_hold_done = (r_hold_cnt == HW'(RST_HOLD - 1));
    // Misaligned PC, or any address bit above the memory's byte range set.
    assign w_addr_bad  = (bus.if_addr[1:0] != 2'b00) || (bus.if_addr[31:AW+2] != '0);

    assign load_err   = r_load_err;
    assign load_count = r_load_count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its inputs, independent of block order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_LOAD;
        else      r_state <= w_next_state;
    end

    always_comb begin
        // NOTE: every output gets a default before the case so no path can
        // leave a signal unassigned and infer a latch.
        w_next_state  = r_state;
        w_hs          = 1'b0;
        bus.ld_ready  = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_waddr = r_wptr;
        bus.mem_wdata = bus.ld_data;
        bus.mem_raddr = '0;
        bus.if_gnt    = 1'b0;
        bus.if_fault  = 1'b0;
        bus.if_instr  = NOP_INSTR;
        cpu_rst_n     = 1'b0;
        load_done     = 1'b0;

        unique case (r_state)
            ST_LOAD: begin
                // Reset forces LOAD asynchronously; gate with rst so nothing
                // is accepted or written while reset is still asserted.
                bus.ld_ready = rst;
                w_hs         = bus.ld_valid & rst;
                bus.mem_we   = w_hs;
                if (w_hs && (bus.ld_last || r_wptr == AW'(DEPTH - 1)))
                    w_next_state = ST_HOLD;
            end
            ST_HOLD: begin
                if (w_hold_done) w_next_state = ST_RUN;
            end
            ST_RUN: begin
                cpu_rst_n     = 1'b1;
                load_done     = 1'b1;
                bus.if_gnt    = bus.if_req;
                bus.mem_raddr = bus.if_addr[AW+1:2];
                bus.if_fault  = bus.if_req & w_addr_bad;
                bus.if_instr  = bus.if_fault ? NOP_INSTR : bus.mem_rdata;
                if (reload_req) w_next_state = ST_LOAD;
            end
            default: w_next_state = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr       <= '0;
            r_hold_cnt   <= '0;
            r_load_count <= '0;
            r_load_err   <= 1'b0;
        end else begin
            unique case (r_state)
                ST_LOAD: begin
                    r_hold_cnt <= '0;
                    if (w_hs) begin
                        r_wptr <= r_wptr + 1'b1;
                        if (r_load_count != (AW+1)'(DEPTH))
                            r_load_count <= r_load_count + 1'b1;
                        // Memory full without a last marker: the word is
                        // written, the overflow is flagged and loading stops.
                        if (!bus.ld_last && r_wptr == AW'(DEPTH - 1))
                            r_load_err <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    r_hold_cnt <= w_hold_done ? '0 : r_hold_cnt + 1'b1;
                end
                ST_RUN: begin
                    if (reload_req) begin
                        r_wptr       <= '0;
                        r_load_count <= '0;
                        r_load_err   <= 1'b0;
                    end
                end
                default: r_wptr <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// ---------------------------------------------------------------------------
// tb_imem_boot_ctrl
// Self-checking bench for imem_boot_ctrl. A behavioural model of the memory
// contents (exp_mem) and of the load/fetch rules predicts every output.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
// ---------------------------------------------------------------------------
module tb_imem_boot_ctrl;

    localparam int          DEPTH     = 32;
    localparam int          AW        = 5;
    localparam int          RST_HOLD  = 4;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic          clk = 1'b0;
    logic          rst;
    logic          reload_req;
    logic          cpu_rst_n;
    logic          load_done;
    logic          load_err;
    logic [AW:0]   load_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] tb_mem  [DEPTH] = '{default: 32'h0};
    logic [31:0] exp_mem [DEPTH] = '{default: 32'h0};
    logic [31:0] prog_q  [$];

    imem_boot_ctrl_if #(.AW(AW)) bus ();

    imem_boot_ctrl #(
        .DEPTH    (DEPTH),
        .AW       (AW),
        .RST_HOLD (RST_HOLD),
        .NOP_INSTR(NOP_INSTR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .reload_req(reload_req),
        .cpu_rst_n (cpu_rst_n),
        .load_done (load_done),
        .load_err  (load_err),
        .load_count(load_count)
    );

    always #5 clk = ~clk;

    // Instruction memory: synchronous write, combinational read.
    always @(posedge clk) begin
        if (bus.mem_we) tb_mem[bus.mem_waddr] <= bus.mem_wdata;
    end
    assign bus.mem_rdata = tb_mem[bus.mem_raddr];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One accepted beat at word index idx.
    task automatic do_beat(input int idx, input logic [31:0] data, input logic last);
        @(negedge clk);
        bus.ld_valid = 1'b1;
        bus.ld_data  = data;
        bus.ld_last  = last;
        #1;
        check("beat_ready", bus.ld_ready, 1'b1);
        check("beat_we",    bus.mem_we, 1'b1);
        check("beat_waddr", bus.mem_waddr, idx % DEPTH);
        check("beat_wdata", bus.mem_wdata, data);
        check("beat_count", load_count, idx);
        check("beat_cpurst", cpu_rst_n, 1'b0);
        exp_mem[idx % DEPTH] = data;
    endtask

    // Streams prog_q. With with_last the final entry carries ld_last; without
    // it the queue must be longer than DEPTH and the overflow rules apply.
    task automatic run_load(input bit with_last, input int max_gap);
        int n_acc;
        n_acc = with_last ? prog_q.size() : DEPTH;
        for (int i = 0; i < n_acc; i++) begin
            int gaps;
            gaps = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
            for (int g = 0; g < gaps; g++) begin
                @(negedge clk);
                bus.ld_valid = 1'b0;
                #1;
                check("gap_ready", bus.ld_ready, 1'b1);
                check("gap_we",    bus.mem_we, 1'b0);
            end
            do_beat(i, prog_q[i], with_last && (i == prog_q.size() - 1));
        end
        // Core stays in reset for exactly RST_HOLD cycles after the last beat.
        for (int k = 0; k < RST_HOLD; k++) begin
            @(negedge clk);
            bus.ld_valid = (!with_last && k == 0);
            bus.ld_data  = (!with_last && k == 0) ? prog_q[DEPTH] : 32'h0;
            bus.ld_last  = 1'b0;
            #1;
            check("hold_ready",  bus.ld_ready, 1'b0);
            check("hold_we",     bus.mem_we, 1'b0);
            check("hold_cpurst", cpu_rst_n, 1'b0);
            check("hold_done",   load_done, 1'b0);
            check("hold_count",  load_count, n_acc);
            check("hold_err",    load_err, !with_last);
        end
        @(negedge clk);
        bus.ld_valid = 1'b0;
        #1;
        check("run_cpurst", cpu_rst_n, 1'b1);
        check("run_done",   load_done, 1'b1);
        check("run_err",    load_err, !with_last);
        check("run_count",  load_count, n_acc);
    endtask

    task automatic do_fetch(input logic [31:0] addr, input logic req);
        bit bad;
        int idx;
        @(negedge clk);
        bus.if_req  = req;
        bus.if_addr = addr;
        #1;
        idx = int'((addr / 4) % DEPTH);
        bad = (addr % 4 != 0) || (addr >= DEPTH * 4);
        check("fetch_gnt",   bus.if_gnt, req);
        check("fetch_raddr", bus.mem_raddr, idx);
        check("fetch_fault", bus.if_fault, req && bad);
        check("fetch_instr", bus.if_instr, (req && bad) ? NOP_INSTR : exp_mem[idx]);
        check("fetch_we",    bus.mem_we, 1'b0);
    endtask

    task automatic random_fetches(input int n);
        for (int i = 0; i < n; i++) begin
            logic [31:0] a;
            case ($urandom_range(0, 3))
                0, 1:    a = 32'($urandom_range(0, DEPTH - 1) * 4);
                2:       a = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
                default: a = $urandom | 32'h0000_0100;
            endcase
            do_fetch(a, $urandom_range(0, 4) != 0);
        end
        @(negedge clk);
        bus.if_req = 1'b0;
    endtask

    // Reload pulse with a concurrent fetch at 0x4, then the LOAD state checks.
    task automatic do_reload();
        @(negedge clk);
        reload_req  = 1'b1;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h4;
        #1;
        check("rl_gnt",   bus.if_gnt, 1'b1);
        check("rl_instr", bus.if_instr, exp_mem[1]);
        check("rl_fault", bus.if_fault, 1'b0);
        @(negedge clk);
        reload_req  = 1'b0;
        bus.if_addr = 32'h8;
        #1;
        check("rl_cpurst", cpu_rst_n, 1'b0);
        check("rl_done",   load_done, 1'b0);
        check("rl_count",  load_count, 0);
        check("rl_err",    load_err, 1'b0);
        check("rl_ready",  bus.ld_ready, 1'b1);
        check("rl_gnt_off",   bus.if_gnt, 1'b0);
        check("rl_instr_nop", bus.if_instr, NOP_INSTR);
        check("rl_raddr_0",   bus.mem_raddr, 0);
        bus.if_req = 1'b0;
    endtask

    task automatic fill_random(input int n);
        prog_q.delete();
        for (int i = 0; i < n; i++) prog_q.push_back($urandom);
    endtask

    initial begin
        rst          = 1'b0;
        reload_req   = 1'b0;
        bus.ld_valid = 1'b1;
        bus.ld_data  = 32'hDEAD_BEEF;
        bus.ld_last  = 1'b0;
        bus.if_req   = 1'b1;
        bus.if_addr  = 32'h8;
        #1;
        // Reset state, with a pending beat and fetch that must be ignored.
        check("rst_ready",  bus.ld_ready, 1'b0);
        check("rst_we",     bus.mem_we, 1'b0);
        check("rst_cpurst", cpu_rst_n, 1'b0);
        check("rst_done",   load_done, 1'b0);
        check("rst_gnt",    bus.if_gnt, 1'b0);
        check("rst_fault",  bus.if_fault, 1'b0);
        check("rst_instr",  bus.if_instr, NOP_INSTR);
        check("rst_count",  load_count, 0);
        check("rst_err",    load_err, 1'b0);
        repeat (2) @(negedge clk);
        rst          = 1'b1;
        bus.ld_valid = 1'b0;
        bus.if_req   = 1'b0;

        // Three-word program, continuous valid.
        prog_q = '{32'h0050_0093, 32'h00A0_0113, 32'h0020_81B3};
        run_load(1'b1, 0);
        do_fetch(32'h0000_0008, 1'b1);
        do_fetch(32'h0000_0006, 1'b1);
        do_fetch(32'h0000_0080, 1'b1);
        do_fetch(32'h0000_0000, 1'b0);

        // Same program with valid gaps.
        do_reload();
        run_load(1'b1, 3);
        random_fetches(30);

        // Overflow: 33 words, no last marker.
        do_reload();
        fill_random(DEPTH + 1);
        run_load(1'b0, 1);
        random_fetches(40);
        check("err_sticky", load_err, 1'b1);

        // One-word program.
        do_reload();
        fill_random(1);
        run_load(1'b1, 0);
        random_fetches(10);

        // Reset after 2 of 5 beats, then a fresh 5-word load from address 0.
        do_reload();
        do_beat(0, $urandom, 1'b0);
        do_beat(1, $urandom, 1'b0);
        @(negedge clk);
        rst          = 1'b0;
        bus.ld_valid = 1'b1;
        bus.ld_data  = 32'h1234_5678;
        #1;
        check("mid_rst_count", load_count, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            check("mid_rst_we",    bus.mem_we, 1'b0);
            check("mid_rst_ready", bus.ld_ready, 1'b0);
        end
        @(negedge clk);
        rst          = 1'b1;
        bus.ld_valid = 1'b0;
        fill_random(5);
        run_load(1'b1, 2);
        random_fetches(20);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
